// File: rtl/add_round_key_serial_if.sv
// Operand/result handshake bundle for the serial AddRoundKey unit.
// The master side supplies operands and takes results.
interface add_round_key_serial_if #(
    parameter int BLOCK_W = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] state_in;
    logic [BLOCK_W-1:0] key_in;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] state_out;
    logic               busy;

    modport master (
        output in_valid, state_in, key_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, key_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/add_round_key_serial.sv
// Word-serial AddRoundKey: XORs a captured state/key pair WORD_W bits
// per cycle, least significant word first, then holds the result.
module add_round_key_serial #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
) (
    input  logic clk,
    input  logic reset,
    add_round_key_serial_if.slave bus
);
    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] st_q, st_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] res_q, res_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            key_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        key_d   = key_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.state_in;
                    key_d   = bus.key_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NWORDS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        res_d[i*WORD_W +: WORD_W] =
                            st_q[i*WORD_W +: WORD_W] ^
                            key_q[i*WORD_W +: WORD_W];
                    end
                end
                // Last word: park the counter at 0 instead of wrapping.
                if (cnt_q == CNT_W'(NWORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_out = res_q;
endmodule

// File: tb/tb_add_round_key_serial.sv
// Randomized bench for add_round_key_serial against a whole-block XOR
// model with LSB-first word progress; also 8- and 128-bit word builds.
module tb_add_round_key_serial;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    add_round_key_serial_if #(.BLOCK_W(128)) bus ();
    add_round_key_serial_if #(.BLOCK_W(128)) bus8 ();
    add_round_key_serial_if #(.BLOCK_W(128)) bus128 ();

    add_round_key_serial #(.BLOCK_W(128), .WORD_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    add_round_key_serial #(.BLOCK_W(128), .WORD_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    add_round_key_serial #(.BLOCK_W(128), .WORD_W(128)) dut128 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus128)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result visible after j of the four 32-bit words have been processed.
    function automatic logic [127:0] part(input logic [127:0] v, input int j);
        logic [127:0] m;
        if (j >= 4) m = '1;
        else m = (128'd1 << (32 * j)) - 128'd1;
        return v & m;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Assumes the caller is at a negedge with the DUT idle.
    task automatic do_op(input logic [127:0] s, input logic [127:0] k,
                         input int hold, input bit scramble);
        logic [127:0] exp;
        exp = s ^ k;
        bus.in_valid  = 1'b1;
        bus.state_in  = s;
        bus.key_in    = k;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        chk("acc_busy", 128'(bus.busy), 128'd1);
        chk("acc_rdy", 128'(bus.in_ready), 128'd0);
        chk("acc_out", bus.state_out, 128'd0);
        if (!scramble) bus.in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            if (scramble) begin
                bus.state_in = rnd128();
                bus.key_in   = rnd128();
            end
            @(negedge clk);
            chk("lat_vld", 128'(bus.out_valid), 128'(j == 4));
            chk("partial", bus.state_out, part(exp, j));
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk("hold_vld", 128'(bus.out_valid), 128'd1);
            chk("hold_out", bus.state_out, exp);
            chk("hold_rdy", 128'(bus.in_ready), 128'd0);
            chk("hold_busy", 128'(bus.busy), 128'd1);
            if (h == hold) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("idle_vld", 128'(bus.out_valid), 128'd0);
        chk("idle_rdy", 128'(bus.in_ready), 128'd1);
        chk("idle_busy", 128'(bus.busy), 128'd0);
        chk("idle_keep", bus.state_out, exp);
    endtask

    initial begin
        logic [127:0] s0, k0, pat;
        int c8, c128;
        s0 = 128'h00112233445566778899aabbccddeeff;
        k0 = 128'h000102030405060708090a0b0c0d0e0f;
        pat = {16{8'h5a}};
        reset = 1'b1;
        bus.in_valid = 1'b0;    bus.out_ready = 1'b0;
        bus.state_in = '0;      bus.key_in = '0;
        bus8.in_valid = 1'b0;   bus8.out_ready = 1'b0;
        bus8.state_in = '0;     bus8.key_in = '0;
        bus128.in_valid = 1'b0; bus128.out_ready = 1'b0;
        bus128.state_in = '0;   bus128.key_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", bus.state_out, 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 128'(bus.in_ready), 128'd1);
        chk("rst_vld", 128'(bus.out_valid), 128'd0);

        do_op(s0, k0, 0, 1'b0);
        chk("vector", bus.state_out,
            128'h00102030405060708090a0b0c0d0e0f0);
        do_op(s0, k0, 5, 1'b0);

        // Reset two cycles into BUSY aborts the operation.
        bus.in_valid  = 1'b1;
        bus.state_in  = s0;
        bus.key_in    = k0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_part", bus.state_out, part(s0 ^ k0, 2));
        reset = 1'b1;
        #1;
        chk("abort_out", bus.state_out, 128'd0);
        chk("abort_vld", 128'(bus.out_valid), 128'd0);
        chk("abort_busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_vld", 128'(bus.out_valid), 128'd0);
        chk("post_rdy", 128'(bus.in_ready), 128'd1);
        do_op(k0, rnd128(), 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            do_op(rnd128(), rnd128(), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end
        do_op(s0, k0, 2, 1'b1);

        bus8.in_valid   = 1'b1;  bus128.in_valid  = 1'b1;
        bus8.state_in   = '1;    bus128.state_in  = '1;
        bus8.key_in     = pat;   bus128.key_in    = pat;
        bus8.out_ready  = 1'b1;  bus128.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus128.in_valid = 1'b0;
        c8 = 0;
        c128 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus8.out_valid && c8 == 0) begin
                c8 = cyc;
                chk("w8_out", bus8.state_out, {16{8'ha5}});
            end
            if (bus128.out_valid && c128 == 0) begin
                c128 = cyc;
                chk("w128_out", bus128.state_out, {16{8'ha5}});
            end
        end
        chk("w8_lat", 128'(c8), 128'd16);
        chk("w128_lat", 128'(c128), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_round_key_serial.md
ADD_ROUND_KEY_SERIAL -- requirements
Module: add_round_key_serial

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, total state/key width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, bits XORed per cycle; BLOCK_W SHALL be an integer multiple of WORD_W (NWORDS = BLOCK_W/WORD_W, NWORDS >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  state_in/key_in present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port state_in  input  BLOCK_W  state operand.
REQ-008 SHALL have port key_in  input  BLOCK_W  round-key operand.
REQ-009 SHALL have port out_valid  output  1  state_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port state_out  output  BLOCK_W  state_in XOR key_in.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 in BUSY and DONE.
REQ-014 Accept = in_valid && in_ready at a rising edge; on accept, operands SHALL be captured into internal registers, result register cleared to 0, word counter set to 0, FSM moves IDLE->BUSY.
REQ-015 Inputs SHALL be ignored when in_ready = 0; captured operands SHALL not follow later input changes.
REQ-016 In BUSY each edge SHALL write result[i*WORD_W +: WORD_W] = state_cap[i*WORD_W +: WORD_W] ^ key_cap[i*WORD_W +: WORD_W] for i = counter, then increment counter; word 0 is the least significant slice.
REQ-017 When the edge processing word NWORDS-1 occurs, FSM SHALL move BUSY->DONE and the counter SHALL return to 0 (no wrap beyond NWORDS-1).
REQ-018 Latency: accept at edge k -> out_valid high after edge k+NWORDS; NWORDS=1 gives one BUSY cycle.
REQ-019 state_out SHALL be driven directly from the result register; during BUSY unprocessed words read 0.
REQ-020 In DONE, state_out and out_valid SHALL hold stable until out_ready = 1 at an edge, then FSM moves DONE->IDLE; state_out keeps its value in IDLE until the next accept.
REQ-021 out_ready outside DONE SHALL have no effect; in_valid in DONE is not accepted (earliest new accept is the edge after leaving DONE).
REQ-022 Counter width SHALL be max(1, clog2(NWORDS)).

Reset
REQ-023 Reset asserted SHALL immediately force FSM=IDLE, counter=0, result=0, captured operands=0, hence in_ready=1 (once reset deasserts), out_valid=0, busy=0, state_out=0.
REQ-024 Reset during BUSY or DONE SHALL abort the operation with no out_valid pulse; first accept possible on the first edge after deassertion.

Verification
REQ-025 Defaults, state_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, in_valid one cycle, out_ready=1 -> out_valid high exactly 4 cycles after accept for 1 cycle, state_out=00102030405060708090a0b0c0d0e0f0.
REQ-026 Same operands, out_ready=0 for 5 cycles after completion -> out_valid and state_out stable for 5 cycles, in_ready=0, busy=1; release -> IDLE next edge.
REQ-027 Defaults, assert reset after 2 BUSY cycles -> state_out=0, out_valid=0, busy=0 immediately; new operand pair afterwards completes correctly in 4 cycles.
REQ-028 WORD_W=8 and WORD_W=128 builds, operands all-ones XOR 0x5a repeated -> state_out all 0xa5 after 16 and 1 cycles respectively.
REQ-029 Change state_in/key_in every cycle during BUSY with in_valid=1 -> result equals XOR of operands captured at accept; no second accept until after DONE handshake.
